riscv_lsu: RTL and testbench

Parametrised load/store unit for the next-generation RISC-V core. It sits between the core's execute/memory stage and the data memory port. It supports:
- byte, halfword, word and (XLEN=64) doubleword accesses, with byte enables;
- sign/zero-extended loads;
- a stall-capable memory handshake with optional timeout;
- misaligned-access handling.

It replaces the fixed single-cycle, word-only `data_*` connection of the current core.

---
 rtl/riscv_lsu_pkg.sv | 36 +++
 rtl/riscv_lsu_align.sv | 87 ++++++++
 rtl/riscv_lsu.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_riscv_lsu.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// ---------------------------------------------------------------------------
// riscv_lsu_pkg
// Shared definitions for the load/store unit: access-size encodings,
// response error codes, the LSU state enum and the size-to-byte-mask helper.
// ---------------------------------------------------------------------------
package riscv_lsu_pkg;

   // Access size encodings as carried on req_size_i
   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic [1:0] SIZE_D = 2'd3;

   // Response error codes as driven on rsp_errcode_o
   localparam logic [1:0] ERRC_NONE     = 2'd0;
   localparam logic [1:0] ERRC_MISALIGN = 2'd1;
   localparam logic [1:0] ERRC_TIMEOUT  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BEAT0,
      ST_BEAT1,
      ST_ERR
   } lsu_state_e;

   // Unshifted byte-enable pattern for an access of the given size
   function automatic logic [7:0] size_to_mask(input logic [1:0] size);
      case (size)
         SIZE_B:  return 8'h01;
         SIZE_H:  return 8'h03;
         SIZE_W:  return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// ---------------------------------------------------------------------------
// riscv_lsu_align
// Combinational lane steering for the LSU.
//   Store side: shifts store data and the size byte-mask up to the byte
//   offset inside the XLEN/8-byte beat.
//   Load side : shifts beat data down by the byte offset, masks to the access
//   size and sign- or zero-extends.
// Build option RISCV_LSU_MISALIGN_SPLIT_EN adds the second-beat store lanes
// (st_data_hi/st_be_hi) and the second-beat load input (ld_hi) so that an
// access crossing a beat boundary can be split and merged.
// Ports:
//   st_size, st_off, st_wdata   : store size, byte offset, LSB-aligned data
//   st_data_lo/st_be_lo         : lanes for the first (floor) beat
//   st_data_hi/st_be_hi         : lanes for the second beat (split build)
//   ld_size, ld_uns, ld_off     : load size, zero-extend flag, byte offset
//   ld_lo / ld_hi               : first / second beat read data
//   ld_data                     : aligned, extended load result
// ---------------------------------------------------------------------------
module riscv_lsu_align
   import riscv_lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]                     st_size,
   input  logic [$clog2(XLEN/8)-1:0]      st_off,
   input  logic [XLEN-1:0]                st_wdata,
   output logic [XLEN-1:0]                st_data_lo,
   output logic [XLEN/8-1:0]              st_be_lo,
`ifdef RISCV_LSU_MISALIGN_SPLIT_EN
   output logic [XLEN-1:0]                st_data_hi,
   output logic [XLEN/8-1:0]              st_be_hi,
   input  logic [XLEN-1:0]                ld_hi,
`endif
   input  logic [1:0]                     ld_size,
   input  logic                           ld_uns,
   input  logic [$clog2(XLEN/8)-1:0]      ld_off,
   input  logic [XLEN-1:0]                ld_lo,
   output logic [XLEN-1:0]                ld_data
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);

   logic [OFF_W+2:0] st_sh;
   logic [OFF_W+2:0] ld_sh;
   logic [NB-1:0]    st_mask;
   logic [XLEN-1:0]  ld_shifted;
   logic [6:0]       ld_bits;
   logic [XLEN-1:0]  ext_mask;
   logic             ld_sign;

   assign st_sh   = {st_off, 3'b000};
   assign ld_sh   = {ld_off, 3'b000};
   assign st_mask = NB'(size_to_mask(st_size));

`ifdef RISCV_LSU_MISALIGN_SPLIT_EN
   // Shift across a double-width window; the upper half feeds the second beat
   logic [2*XLEN-1:0] st_wide;
   logic [2*NB-1:0]   be_wide;

   assign st_wide                  = {{XLEN{1'b0}}, st_wdata} << st_sh;
   assign be_wide                  = {{NB{1'b0}}, st_mask} << st_off;
   assign {st_data_hi, st_data_lo} = st_wide;
   assign {st_be_hi, st_be_lo}     = be_wide;
   assign ld_shifted               = XLEN'({ld_hi, ld_lo} >> ld_sh);
`else
   assign st_data_lo = st_wdata << st_sh;
   assign st_be_lo   = st_mask << st_off;
   assign ld_shifted = ld_lo >> ld_sh;
`endif

   // Width in bits of the access; a shift of >= XLEN yields an all-ones mask
   assign ld_bits  = 7'd8 << ld_size;
   assign ext_mask = ~({XLEN{1'b1}} << ld_bits);

   always_comb begin
      case (ld_size)
         SIZE_B:  ld_sign = ld_shifted[7];
         SIZE_H:  ld_sign = ld_shifted[15];
         SIZE_W:  ld_sign = ld_shifted[31];
         default: ld_sign = ld_shifted[XLEN-1];
      endcase
   end

   assign ld_data = (ld_shifted & ext_mask) | ((ld_sign && !ld_uns) ? ~ext_mask : '0);

endmodule

// File: rtl/riscv_lsu.sv
// ---------------------------------------------------------------------------
// riscv_lsu
// Load/store unit between the core memory stage and the data memory port.
// Byte/half/word (and dword when XLEN=64) accesses with byte enables,
// sign/zero-extended loads, stall-capable handshake with optional timeout,
// misaligned-access detection.
// Build option: RISCV_LSU_MISALIGN_SPLIT_EN -- misaligned accesses are
// serviced (one beat when contained in a beat, two beats when crossing);
// without it every misaligned access responds with errcode 1.
// Parameters: XLEN (32/64), ADDR_W, MAX_WAIT (0 = no timeout).
// Ports:
//   clk, rst (async, active low)
//   req_valid_i/req_ready_o, req_we_i, req_size_i, req_unsigned_i,
//   req_addr_i, req_wdata_i                      : core request
//   rsp_valid_o, rsp_rdata_o, rsp_err_o,
//   rsp_errcode_o                                : one-cycle response
//   data_ce_o, data_we_o, data_be_o, data_addr_o,
//   data_o, data_i, data_ack_i                   : memory port
// ---------------------------------------------------------------------------
module riscv_lsu
   import riscv_lsu_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int ADDR_W   = 32,
   parameter int MAX_WAIT = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_we_i,
   input  logic [1:0]          req_size_i,
   input  logic                req_unsigned_i,
   input  logic [ADDR_W-1:0]   req_addr_i,
   input  logic [XLEN-1:0]     req_wdata_i,
   output logic                rsp_valid_o,
   output logic [XLEN-1:0]     rsp_rdata_o,
   output logic                rsp_err_o,
   output logic [1:0]          rsp_errcode_o,
   output logic                data_ce_o,
   output logic                data_we_o,
   output logic [XLEN/8-1:0]   data_be_o,
   output logic [ADDR_W-1:0]   data_addr_o,
   output logic [XLEN-1:0]     data_o,
   input  logic [XLEN-1:0]     data_i,
   input  logic                data_ack_i
);

   localparam int NB     = XLEN / 8;
   localparam int OFF_W  = $clog2(NB);
   localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

   lsu_state_e state_q, state_d;

   logic              we_q, we_d;
   logic              uns_q, uns_d;
   logic [1:0]        size_q, size_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic [WAIT_W-1:0] wait_q, wait_d;

   logic              ce_d, wen_d;
   logic [NB-1:0]     be_d;
   logic [ADDR_W-1:0] addr_d;
   logic [XLEN-1:0]   dout_d;
   logic              rsp_valid_d, rsp_err_d;
   logic [XLEN-1:0]   rsp_rdata_d;
   logic [1:0]        code_d;

   logic [1:0]        req_size_eff;
   logic [OFF_W-1:0]  req_off;
   logic [OFF_W-1:0]  req_amask;
   logic [ADDR_W-1:0] req_floor;
   logic              tmo_hit;
   logic              beat_done, beat_tmo;

   logic [XLEN-1:0]   st_data_lo;
   logic [NB-1:0]     st_be_lo;
   logic [XLEN-1:0]   ld_lo;
   logic [XLEN-1:0]   ld_data;

`ifdef RISCV_LSU_MISALIGN_SPLIT_EN
   logic [XLEN-1:0]   st_data_hi;
   logic [NB-1:0]     st_be_hi;
   logic [XLEN-1:0]   ld_hi;
   logic              split_q, split_d;
   logic [XLEN-1:0]   hi_data_q, hi_data_d;
   logic [NB-1:0]     hi_be_q, hi_be_d;
   logic [ADDR_W-1:0] hi_addr_q, hi_addr_d;
   logic [XLEN-1:0]   lo_rdata_q, lo_rdata_d;
`else
   logic              req_misal;
`endif

   assign req_ready_o  = (state_q == ST_IDLE);

   // A dword request on a 32-bit core is serviced as a word
   assign req_size_eff = (XLEN == 32 && req_size_i == SIZE_D) ? SIZE_W : req_size_i;
   assign req_off      = req_addr_i[OFF_W-1:0];
   assign req_amask    = OFF_W'((4'd1 << req_size_eff) - 4'd1);
   assign req_floor    = {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign tmo_hit      = (MAX_WAIT > 0) && !data_ack_i && (wait_q == WAIT_LAST);

`ifdef RISCV_LSU_MISALIGN_SPLIT_EN
   // The second beat's data is only meaningful while BEAT1 completes
   assign ld_lo = (state_q == ST_BEAT1) ? lo_rdata_q : data_i;
   assign ld_hi = (state_q == ST_BEAT1) ? data_i : '0;
`else
   assign ld_lo     = data_i;
   assign req_misal = |(req_off & req_amask);
`endif

   riscv_lsu_align #(
      .XLEN (XLEN)
   ) u_align (
      .st_size    (req_size_eff),
      .st_off     (req_off),
      .st_wdata   (req_wdata_i),
      .st_data_lo (st_data_lo),
      .st_be_lo   (st_be_lo),
`ifdef RISCV_LSU_MISALIGN_SPLIT_EN
      .st_data_hi (st_data_hi),
      .st_be_hi   (st_be_hi),
      .ld_hi      (ld_hi),
`endif
      .ld_size    (size_q),
      .ld_uns     (uns_q),
      .ld_off     (off_q),
      .ld_lo      (ld_lo),
      .ld_data    (ld_data)
   );

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      uns_d       = uns_q;
      size_d      = size_q;
      off_d       = off_q;
      wait_d      = wait_q;
      ce_d        = data_ce_o;
      wen_d       = data_we_o;
      be_d        = data_be_o;
      addr_d      = data_addr_o;
      dout_d      = data_o;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
      code_d      = ERRC_NONE;
      beat_done   = 1'b0;
      beat_tmo    = 1'b0;
`ifdef RISCV_LSU_MISALIGN_SPLIT_EN
      split_d     = split_q;
      hi_data_d   = hi_data_q;
      hi_be_d     = hi_be_q;
      hi_addr_d   = hi_addr_q;
      lo_rdata_d  = lo_rdata_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               we_d   = req_we_i;
               uns_d  = req_unsigned_i;
               size_d = req_size_eff;
               off_d  = req_off;
               wait_d = '0;
`ifdef RISCV_LSU_MISALIGN_SPLIT_EN
               state_d   = ST_BEAT0;
               ce_d      = 1'b1;
               wen_d     = req_we_i;
               be_d      = st_be_lo;
               addr_d    = req_floor;
               dout_d    = req_we_i ? st_data_lo : '0;
               // Any enabled byte in the upper window means the access crosses
               split_d   = |st_be_hi;
               hi_be_d   = st_be_hi;
               hi_data_d = req_we_i ? st_data_hi : '0;
               hi_addr_d = req_floor + ADDR_W'(NB);
`else
               if (req_misal) begin
                  state_d = ST_ERR;
               end else begin
                  state_d = ST_BEAT0;
                  ce_d    = 1'b1;
                  wen_d   = req_we_i;
                  be_d    = st_be_lo;
                  addr_d  = req_floor;
                  dout_d  = req_we_i ? st_data_lo : '0;
               end
`endif
            end
         end

         ST_BEAT0: begin
            if (data_ack_i) begin
`ifdef RISCV_LSU_MISALIGN_SPLIT_EN
               if (split_q) begin
                  state_d    = ST_BEAT1;
                  be_d       = hi_be_q;
                  addr_d     = hi_addr_q;
                  dout_d     = hi_data_q;
                  lo_rdata_d = data_i;
                  wait_d     = '0;
               end else begin
                  beat_done = 1'b1;
               end
`else
               beat_done = 1'b1;
`endif
            end else if (tmo_hit) begin
               beat_tmo = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end

`ifdef RISCV_LSU_MISALIGN_SPLIT_EN
         ST_BEAT1: begin
            if (data_ack_i) begin
               beat_done = 1'b1;
            end else if (tmo_hit) begin
               beat_tmo = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
`endif

         ST_ERR: begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            code_d      = ERRC_MISALIGN;
         end

         default: state_d = ST_IDLE;
      endcase

      // Common completion of the last beat, whether by ack or by timeout
      if (beat_done || beat_tmo) begin
         state_d     = ST_IDLE;
         ce_d        = 1'b0;
         wen_d       = 1'b0;
         be_d        = '0;
         addr_d      = '0;
         dout_d      = '0;
         rsp_valid_d = 1'b1;
         if (beat_tmo) begin
            rsp_err_d = 1'b1;
            code_d    = ERRC_TIMEOUT;
         end else if (!we_q) begin
            rsp_rdata_d = ld_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         we_q          <= 1'b0;
         uns_q         <= 1'b0;
         size_q        <= SIZE_B;
         off_q         <= '0;
         wait_q        <= '0;
         data_ce_o     <= 1'b0;
         data_we_o     <= 1'b0;
         data_be_o     <= '0;
         data_addr_o   <= '0;
         data_o        <= '0;
         rsp_valid_o   <= 1'b0;
         rsp_rdata_o   <= '0;
         rsp_err_o     <= 1'b0;
         rsp_errcode_o <= ERRC_NONE;
`ifdef RISCV_LSU_MISALIGN_SPLIT_EN
         split_q       <= 1'b0;
         hi_data_q     <= '0;
         hi_be_q       <= '0;
         hi_addr_q     <= '0;
         lo_rdata_q    <= '0;
`endif
      end else begin
         state_q       <= state_d;
         we_q          <= we_d;
         uns_q         <= uns_d;
         size_q        <= size_d;
         off_q         <= off_d;
         wait_q        <= wait_d;
         data_ce_o     <= ce_d;
         data_we_o     <= wen_d;
         data_be_o     <= be_d;
         data_addr_o   <= addr_d;
         data_o        <= dout_d;
         rsp_valid_o   <= rsp_valid_d;
         rsp_rdata_o   <= rsp_rdata_d;
         rsp_err_o     <= rsp_err_d;
         rsp_errcode_o <= code_d;
`ifdef RISCV_LSU_MISALIGN_SPLIT_EN
         split_q       <= split_d;
         hi_data_q     <= hi_data_d;
         hi_be_q       <= hi_be_d;
         hi_addr_q     <= hi_addr_d;
         lo_rdata_q    <= lo_rdata_d;
`endif
      end
   end

endmodule

// File: tb/tb_riscv_lsu.sv
// ---------------------------------------------------------------------------
// tb_riscv_lsu
// Directed bench for riscv_lsu (XLEN=32, MAX_WAIT=4). Expected responses are
// queued when a request is issued; a monitor pops and compares on every
// rsp_valid_o pulse. Memory-port signals are checked while beats are served.
// Misaligned expectations follow RISCV_LSU_MISALIGN_SPLIT_EN.
// ---------------------------------------------------------------------------
module tb_riscv_lsu;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [1:0]  req_size_i = 2'd0;
   logic        req_unsigned_i = 1'b0;
   logic [31:0] req_addr_i = '0;
   logic [31:0] req_wdata_i = '0;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic [1:0]  rsp_errcode_o;
   logic        data_ce_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o;
   logic [31:0] data_o;
   logic [31:0] data_i = '0;
   logic        data_ack_i = 1'b0;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic [1:0]  code;
   } rsp_t;

   rsp_t exp_q[$];
   rsp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   riscv_lsu #(
      .XLEN     (32),
      .ADDR_W   (32),
      .MAX_WAIT (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_we_i       (req_we_i),
      .req_size_i     (req_size_i),
      .req_unsigned_i (req_unsigned_i),
      .req_addr_i     (req_addr_i),
      .req_wdata_i    (req_wdata_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_rdata_o    (rsp_rdata_o),
      .rsp_err_o      (rsp_err_o),
      .rsp_errcode_o  (rsp_errcode_o),
      .data_ce_o      (data_ce_o),
      .data_we_o      (data_we_o),
      .data_be_o      (data_be_o),
      .data_addr_o    (data_addr_o),
      .data_o         (data_o),
      .data_i         (data_i),
      .data_ack_i     (data_ack_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] rdata, input logic err, input logic [1:0] code);
      exp_q.push_back('{rdata: rdata, err: err, code: code});
   endtask

   // Response monitor: every pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst && rsp_valid_o) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected got rdata=%0h err=%0b code=%0d exp none",
                     rsp_rdata_o, rsp_err_o, rsp_errcode_o);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata_o, mon_e.rdata);
            chk("rsp_err", rsp_err_o, mon_e.err);
            chk("rsp_code", rsp_errcode_o, mon_e.code);
         end
      end
   end

   task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
      @(negedge clk);
      for (int i = 0; i < 20 && !req_ready_o; i++) @(negedge clk);
      chk("req_ready", req_ready_o, 1);
      req_valid_i    = 1'b1;
      req_we_i       = we;
      req_size_i     = sz;
      req_unsigned_i = uns;
      req_addr_i     = addr;
      req_wdata_i    = wd;
      @(posedge clk);
      #1;
      req_valid_i    = 1'b0;
      req_wdata_i    = '0;
   endtask

   // Serve one beat with the given number of wait states, checking the
   // memory-port request is present and stable on every cycle it is held
   task automatic beat(input int waits, input logic [31:0] rd, input logic [31:0] ea,
                       input logic [3:0] ebe, input logic ewe, input logic [31:0] edata);
      for (int c = 0; c <= waits; c++) begin
         @(negedge clk);
         chk("ce", data_ce_o, 1);
         chk("addr", data_addr_o, ea);
         chk("be", data_be_o, ebe);
         chk("we", data_we_o, ewe);
         if (ewe) chk("wdata", data_o, edata);
         if (c == waits) begin
            data_ack_i = 1'b1;
            data_i     = rd;
         end
         @(posedge clk);
         #1;
         data_ack_i = 1'b0;
         data_i     = '0;
      end
   endtask

   task automatic fin();
      @(negedge clk);
      chk("ce_drop", data_ce_o, 0);
      chk("rsp_timing", rsp_valid_o, 1);
      chk("ready_back", req_ready_o, 1);
   endtask

   task automatic misal_err(input logic we, input logic [1:0] sz, input logic [31:0] addr);
      push_exp(32'h0, 1'b1, 2'd1);
      issue(we, sz, 1'b0, addr, 32'h0);
      @(negedge clk);
      chk("misal_no_ce", data_ce_o, 0);
      chk("misal_no_early_rsp", rsp_valid_o, 0);
      @(negedge clk);
      chk("misal_no_ce2", data_ce_o, 0);
      chk("misal_rsp_cycle", rsp_valid_o, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("rst_ready", req_ready_o, 1);
      chk("rst_ce", data_ce_o, 0);
      chk("rst_we", data_we_o, 0);
      chk("rst_be", data_be_o, 0);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      chk("rst_rdata", rsp_rdata_o, 0);
      chk("rst_err", rsp_err_o, 0);
      chk("rst_code", rsp_errcode_o, 0);
      @(negedge clk);
      rst = 1'b1;

      // sw 0xDEADBEEF @0x100, zero wait
      push_exp(32'h0, 1'b0, 2'd0);
      issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
      beat(0, 32'h0, 32'h100, 4'hF, 1'b1, 32'hDEADBEEF);
      fin();

      // lb / lbu @0x103
      push_exp(32'hFFFFFF80, 1'b0, 2'd0);
      issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
      beat(0, 32'h80112233, 32'h100, 4'h8, 1'b0, 32'h0);
      fin();
      push_exp(32'h00000080, 1'b0, 2'd0);
      issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
      beat(0, 32'h80112233, 32'h100, 4'h8, 1'b0, 32'h0);
      fin();

      // sb @0x101, sh @0x102: lane shifts
      push_exp(32'h0, 1'b0, 2'd0);
      issue(1'b1, 2'd0, 1'b0, 32'h101, 32'h000000AB);
      beat(0, 32'h0, 32'h100, 4'h2, 1'b1, 32'h0000AB00);
      fin();
      push_exp(32'h0, 1'b0, 2'd0);
      issue(1'b1, 2'd1, 1'b0, 32'h102, 32'h00001234);
      beat(1, 32'h0, 32'h100, 4'hC, 1'b1, 32'h12340000);
      fin();

      // lh @0x102 with two wait states
      push_exp(32'hFFFFBEEF, 1'b0, 2'd0);
      issue(1'b0, 2'd1, 1'b0, 32'h102, 32'h0);
      beat(2, 32'hBEEF1234, 32'h100, 4'hC, 1'b0, 32'h0);
      fin();

      // lhu @0x100
      push_exp(32'h0000F00D, 1'b0, 2'd0);
      issue(1'b0, 2'd1, 1'b1, 32'h100, 32'h0);
      beat(0, 32'h1234F00D, 32'h100, 4'h3, 1'b0, 32'h0);
      fin();

      // size 3 on XLEN=32 behaves as a word
      push_exp(32'h87654321, 1'b0, 2'd0);
      issue(1'b0, 2'd3, 1'b0, 32'h104, 32'h0);
      beat(0, 32'h87654321, 32'h104, 4'hF, 1'b0, 32'h0);
      fin();

`ifdef RISCV_LSU_MISALIGN_SPLIT_EN
      // lw @0x101 split across two beats
      push_exp(32'h55443322, 1'b0, 2'd0);
      issue(1'b0, 2'd2, 1'b0, 32'h101, 32'h0);
      beat(0, 32'h44332211, 32'h100, 4'hE, 1'b0, 32'h0);
      beat(0, 32'h88776655, 32'h104, 4'h1, 1'b0, 32'h0);
      fin();
      // sh @0x101 contained in one beat
      push_exp(32'h0, 1'b0, 2'd0);
      issue(1'b1, 2'd1, 1'b0, 32'h101, 32'h0000BEEF);
      beat(0, 32'h0, 32'h100, 4'h6, 1'b1, 32'h00BEEF00);
      fin();
`else
      misal_err(1'b0, 2'd2, 32'h101);
      misal_err(1'b1, 2'd1, 32'h101);
`endif

      // Timeout: ack never comes, ce held exactly MAX_WAIT cycles
      push_exp(32'h0, 1'b1, 2'd2);
      issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("tmo_ce_held", data_ce_o, 1);
      end
      @(negedge clk);
      chk("tmo_ce_drop", data_ce_o, 0);
      chk("tmo_rsp", rsp_valid_o, 1);
      chk("tmo_ready", req_ready_o, 1);

      // Reset while a store waits for ack: no response may follow
      issue(1'b1, 2'd2, 1'b0, 32'h300, 32'h11223344);
      @(negedge clk);
      chk("rstw_ce_before", data_ce_o, 1);
      chk("rstw_we_before", data_we_o, 1);
      rst = 1'b0;
      #1;
      chk("rstw_ce", data_ce_o, 0);
      chk("rstw_we", data_we_o, 0);
      chk("rstw_be", data_be_o, 0);
      chk("rstw_rsp_valid", rsp_valid_o, 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rstw_ready", req_ready_o, 1);
      chk("rstw_ce_idle", data_ce_o, 0);

      // Normal operation resumes after reset
      push_exp(32'h000000AA, 1'b0, 2'd0);
      issue(1'b0, 2'd0, 1'b1, 32'h001, 32'h0);
      beat(0, 32'h0000AA00, 32'h000, 4'h2, 1'b0, 32'h0);
      fin();

      repeat (2) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
